// File: rtl/afifo_pkg.sv
// Shared helpers for the asynchronous FIFO controllers: pointer width,
// Gray/binary conversion and the full-pattern comparison.
package afifo_pkg;

    // Pointer width: one extra MSB beyond the address distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Mask selecting the low w bits of a 32-bit container.
    function automatic logic [31:0] width_mask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    // Binary to Gray for a w-bit value carried zero-extended in 32 bits.
    function automatic logic [31:0] bin2gray(input logic [31:0] b, input int w);
        logic [31:0] bm;
        bm = b & width_mask(w);
        return bm ^ (bm >> 1);
    endfunction

    // Gray to binary for a w-bit value carried zero-extended in 32 bits.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
        logic [31:0] gm;
        logic [31:0] b;
        gm    = g & width_mask(w);
        b     = '0;
        b[31] = gm[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ gm[i];
        end
        return b;
    endfunction

    // Write pointer is exactly one lap ahead of the read pointer when its Gray
    // code equals the read Gray code with the two top bits inverted.
    function automatic logic full_match(input logic [31:0] wgray, input logic [31:0] rgray,
                                        input int w);
        logic [31:0] pattern;
        pattern = (rgray ^ (32'h3 << (w - 2))) & width_mask(w);
        return (wgray & width_mask(w)) == pattern;
    endfunction

endpackage

// File: rtl/afifo_wr_ctrl_if.sv
// Write-side bundle between the producer/read-domain glue and the write controller.
interface afifo_wr_ctrl_if
    import afifo_pkg::*;
#(
    parameter int Depth = 512
);
    localparam int AddrLines = $clog2(Depth);
    localparam int PtrW      = ptr_width(Depth);

    logic                 WRreq;
    logic [PtrW-1:0]      RDptrGray;
    logic                 WRen;
    logic [AddrLines-1:0] WRaddr;
    logic [PtrW-1:0]      WRptrGray;
    logic                 Full;
    logic                 AlmostFull;
    logic [PtrW-1:0]      WRlevel;
    logic                 Overflow;

    // Producer side: issues pushes and forwards the read-domain Gray pointer.
    modport master (
        output WRreq, RDptrGray,
        input  WRen, WRaddr, WRptrGray, Full, AlmostFull, WRlevel, Overflow
    );

    // Controller side.
    modport slave (
        input  WRreq, RDptrGray,
        output WRen, WRaddr, WRptrGray, Full, AlmostFull, WRlevel, Overflow
    );
endinterface

// File: rtl/gray_sync.sv
// Plain flop chain for bringing a Gray pointer across clock domains.
// No logic between stages so each bit resolves metastability independently.
module gray_sync #(
    parameter int Width  = 4,
    parameter int Stages = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);
    for (genvar gi = 0; gi < Stages; gi++) begin : g_stage
        logic [Width-1:0] q_reg;
        if (gi == 0) begin : g_first
            // First stage samples the foreign-domain pointer.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) q_reg <= '0;
                else     q_reg <= d;
            end
        end else begin : g_next
            // Later stages simply retime the previous stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) q_reg <= '0;
                else     q_reg <= g_stage[gi-1].q_reg;
            end
        end
    end

    assign q = g_stage[Stages-1].q_reg;
endmodule

// File: rtl/afifo_wr_ctrl.sv
// Write-side controller of the asynchronous FIFO: accepts pushes, drives the
// SRAM write port, keeps binary/Gray write pointers and derives pessimistic
// Full / AlmostFull / level / Overflow flags from the synchronized read pointer.
module afifo_wr_ctrl
    import afifo_pkg::*;
#(
    parameter int Depth         = 512,
    parameter int AlmostFullThr = Depth - 4,
    parameter int SyncStages    = 2
) (
    input  logic            WRclk,
    input  logic            WRrst,
    afifo_wr_ctrl_if.slave  wr
);
    localparam int AddrLines = $clog2(Depth);
    localparam int PtrW      = ptr_width(Depth);

    logic [PtrW-1:0] wbin_reg;
    logic [PtrW-1:0] wgray_reg;
    logic [PtrW-1:0] level_reg;
    logic            full_reg;
    logic            afull_reg;
    logic            ovf_reg;

    logic [PtrW-1:0] rq;
    logic [PtrW-1:0] rbin;
    logic [PtrW-1:0] wbin_next;
    logic [PtrW-1:0] wgray_next;
    logic [PtrW-1:0] level_next;
    logic            full_next;
    logic            afull_next;
    logic            wen;

    gray_sync #(
        .Width  (PtrW),
        .Stages (SyncStages)
    ) u_rdptr_sync (
        .clk (WRclk),
        .rst (WRrst),
        .d   (wr.RDptrGray),
        .q   (rq)
    );

    // Accept a push unless full; flags use the pointer after this cycle's write.
    always_comb begin
        wen        = wr.WRreq & ~full_reg & ~WRrst;
        wbin_next  = wbin_reg + PtrW'(wen);
        wgray_next = PtrW'(bin2gray(32'(wbin_next), PtrW));
        rbin       = PtrW'(gray2bin(32'(rq), PtrW));
        level_next = wbin_next - rbin;
        full_next  = full_match(32'(wgray_next), 32'(rq), PtrW);
        afull_next = (int'(level_next) >= AlmostFullThr);
    end

    // Pointer and flag registers; overflow is sticky until reset.
    always_ff @(posedge WRclk or posedge WRrst) begin
        if (WRrst) begin
            wbin_reg  <= '0;
            wgray_reg <= '0;
            level_reg <= '0;
            full_reg  <= 1'b0;
            afull_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            wbin_reg  <= wbin_next;
            wgray_reg <= wgray_next;
            level_reg <= level_next;
            full_reg  <= full_next;
            afull_reg <= afull_next;
            ovf_reg   <= ovf_reg | (wr.WRreq & full_reg);
        end
    end

    assign wr.WRen       = wen;
    assign wr.WRaddr     = wbin_reg[AddrLines-1:0];
    assign wr.WRptrGray  = wgray_reg;
    assign wr.Full       = full_reg;
    assign wr.AlmostFull = afull_reg;
    assign wr.WRlevel    = level_reg;
    assign wr.Overflow   = ovf_reg;

    // The synchronized read pointer must never be ahead of the write pointer.
    logic [PtrW-1:0] occupancy;
    assign occupancy = wbin_reg - rbin;

    a_rd_not_ahead : assert property (@(posedge WRclk) disable iff (WRrst)
        int'(occupancy) <= Depth);

    a_gray_one_bit : assert property (@(posedge WRclk) disable iff (WRrst)
        $countones(wgray_reg ^ $past(wgray_reg)) <= 1);

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Directed bench for afifo_wr_ctrl (Depth=8, AlmostFullThr=4, SyncStages=2).
// The driver issues one vector per cycle and queues its expected response;
// a monitor on the falling edge pops and compares.
module tb_afifo_wr_ctrl;
    localparam int DEPTH = 8;

    logic WRclk;
    logic WRrst;

    afifo_wr_ctrl_if #(.Depth(DEPTH)) wr ();

    afifo_wr_ctrl #(
        .Depth         (DEPTH),
        .AlmostFullThr (4),
        .SyncStages    (2)
    ) dut (
        .WRclk (WRclk),
        .WRrst (WRrst),
        .wr    (wr)
    );

    initial WRclk = 1'b0;
    always #5 WRclk = ~WRclk;

    // Field mask bits
    localparam int M_WEN   = 1;
    localparam int M_ADDR  = 2;
    localparam int M_GRAY  = 4;
    localparam int M_FULL  = 8;
    localparam int M_AFULL = 16;
    localparam int M_LEVEL = 32;
    localparam int M_OVF   = 64;
    localparam int M_ALL   = 127;

    typedef struct {
        string      name;
        int         mask;
        logic       wen;
        logic [2:0] addr;
        logic [3:0] gray;
        logic       full;
        logic       afull;
        logic [3:0] level;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Hand-written 4-bit Gray sequence 0..15
    logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                              4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};

    function automatic exp_t ex(input string n, input int m, input logic wen,
                                input int addr, input logic [3:0] gray, input logic full,
                                input logic afull, input int level, input logic ovf);
        exp_t e;
        e.name  = n;
        e.mask  = m;
        e.wen   = wen;
        e.addr  = 3'(addr);
        e.gray  = gray;
        e.full  = full;
        e.afull = afull;
        e.level = 4'(level);
        e.ovf   = ovf;
        return e;
    endfunction

    task automatic chk(input string n, input string f, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s.%s got=%0h want=%0h", n, f, act, want);
        end
    endtask

    // Monitor: one transaction per cycle, compared mid-cycle.
    always @(negedge WRclk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            if ((e.mask & M_WEN)   != 0) chk(e.name, "WRen",       int'(wr.WRen),       int'(e.wen));
            if ((e.mask & M_ADDR)  != 0) chk(e.name, "WRaddr",     int'(wr.WRaddr),     int'(e.addr));
            if ((e.mask & M_GRAY)  != 0) chk(e.name, "WRptrGray",  int'(wr.WRptrGray),  int'(e.gray));
            if ((e.mask & M_FULL)  != 0) chk(e.name, "Full",       int'(wr.Full),       int'(e.full));
            if ((e.mask & M_AFULL) != 0) chk(e.name, "AlmostFull", int'(wr.AlmostFull), int'(e.afull));
            if ((e.mask & M_LEVEL) != 0) chk(e.name, "WRlevel",    int'(wr.WRlevel),    int'(e.level));
            if ((e.mask & M_OVF)   != 0) chk(e.name, "Overflow",   int'(wr.Overflow),   int'(e.ovf));
            $display("txn %-14s req=%0d rst=%0d rdg=%b wen=%0d addr=%0d gray=%b full=%0d af=%0d lvl=%0d ovf=%0d",
                     e.name, wr.WRreq, WRrst, wr.RDptrGray, wr.WRen, wr.WRaddr,
                     wr.WRptrGray, wr.Full, wr.AlmostFull, wr.WRlevel, wr.Overflow);
        end
    end

    // Drive one cycle of inputs just after the rising edge and queue the expectation.
    task automatic step(input logic req, input logic rst, input logic [3:0] rdg, input exp_t e);
        @(posedge WRclk);
        #1;
        wr.WRreq     = req;
        WRrst        = rst;
        wr.RDptrGray = rdg;
        sb_q.push_back(e);
    endtask

    initial begin
        WRrst        = 1'b1;
        wr.WRreq     = 1'b0;
        wr.RDptrGray = 4'b0000;

        // Reset: outputs forced low even with a pending request
        step(1, 1, 4'b0000, ex("rst_hold",   M_ALL, 0, 0, 4'b0000, 0, 0, 0, 0));
        step(0, 0, 4'b0000, ex("rst_release",M_ALL, 0, 0, 4'b0000, 0, 0, 0, 0));

        // Fill eight entries with the reader idle
        for (int i = 0; i < 8; i++)
            step(1, 0, 4'b0000, ex("fill", M_ALL, 1, i, gtab[i], 0, (i >= 4), i, 0));
        step(0, 0, 4'b0000, ex("full_set",   M_ALL, 0, 0, 4'b1100, 1, 1, 8, 0));

        // Push while full is rejected and flagged
        step(1, 0, 4'b0000, ex("push_full",  M_ALL, 0, 0, 4'b1100, 1, 1, 8, 0));
        step(0, 0, 4'b0000, ex("ovf_set",    M_ALL, 0, 0, 4'b1100, 1, 1, 8, 1));

        // Reader advances to 3: Full holds for the sync latency, then drops
        for (int i = 0; i < 3; i++)
            step(0, 0, 4'b0010, ex("release_wait", M_ALL, 0, 0, 4'b1100, 1, 1, 8, 1));
        step(1, 0, 4'b0010, ex("refill0",    M_ALL, 1, 0, 4'b1100, 0, 1, 5, 1));
        step(1, 0, 4'b0010, ex("refill1",    M_ALL, 1, 1, 4'b1101, 0, 1, 6, 1));
        step(1, 0, 4'b0010, ex("refill2",    M_ALL, 1, 2, 4'b1111, 0, 1, 7, 1));
        step(1, 0, 4'b0010, ex("refull",     M_ALL, 0, 3, 4'b1110, 1, 1, 8, 1));

        // Drain completely, then reset in the middle of a burst
        for (int i = 0; i < 3; i++)
            step(0, 0, 4'b1110, ex("drain_wait", 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        step(0, 0, 4'b1110, ex("drained",    M_ALL, 0, 3, 4'b1110, 0, 0, 0, 1));
        step(1, 0, 4'b1110, ex("burst0",     M_WEN | M_ADDR, 1, 3, 4'b0000, 0, 0, 0, 0));
        step(1, 0, 4'b1110, ex("burst1",     M_WEN | M_ADDR, 1, 4, 4'b0000, 0, 0, 0, 0));
        step(1, 1, 4'b0000, ex("rst_mid",    M_ALL, 0, 0, 4'b0000, 0, 0, 0, 0));
        step(1, 1, 4'b0000, ex("rst_mid2",   M_ALL, 0, 0, 4'b0000, 0, 0, 0, 0));
        step(0, 0, 4'b0000, ex("rst_after",  M_ALL, 0, 0, 4'b0000, 0, 0, 0, 0));

        // Wrap: 20 writes with the reader closely following
        for (int k = 0; k < 20; k++)
            step(1, 0, gtab[k % 16], ex("wrap", M_ALL, 1, k % 8, gtab[k % 16], 0, 0,
                                        (k < 3) ? k : 3, 0));
        step(0, 0, gtab[4], ex("wrap_end",   M_ALL, 0, 4, gtab[4], 0, 0, 3, 0));
        step(0, 0, gtab[4], ex("wrap_settle",M_ALL, 0, 4, gtab[4], 0, 0, 2, 0));

        // Simultaneous push and read advance at level 7
        step(0, 1, 4'b0000, ex("rst_e",      M_ALL, 0, 0, 4'b0000, 0, 0, 0, 0));
        step(0, 0, 4'b0000, ex("rst_e_rel",  M_ALL, 0, 0, 4'b0000, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++)
            step(1, 0, (k >= 5) ? 4'b0001 : 4'b0000,
                 ex("simul", M_ALL, 1, k, gtab[k], 0, (k >= 4), k, 0));
        step(0, 0, 4'b0001, ex("simul_hold", M_ALL, 0, 0, 4'b1100, 0, 1, 7, 0));
        step(0, 0, 4'b0001, ex("simul_settle", M_ALL, 0, 0, 4'b1100, 0, 1, 7, 0));

        // Let the monitor consume the last entry
        @(posedge WRclk);
        @(negedge WRclk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
